ire_stage: RTL and testbench
============================

Name: ire_stage

Overview:
- Registered, buffered successor to the combinational instruction-field extractor.
- Accepts raw instruction words with a PC over a valid/ready handshake and decodes fields at accept time.
- Decode covers fields, destination register, extended immediate and control class; decoded entries are held in a DEPTH-entry FIFO.
- Sits between instruction fetch and register read; the FIFO absorbs execute-side stalls; flush supports branch redirect.

Parameters:
- XLEN, 32, instruction/PC width (fields fixed to MIPS32 positions; XLEN>=32)
- DEPTH, 2, decoded-entry FIFO depth; power of 2, >=2
- LINK_REG, 31, destination register forced for jal

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all buffered entries
- in_valid  in  1  instruction present
- in_ready  out  1  stage can accept
- ir  in  32  instruction word
- pc_in  in  XLEN  PC of ir
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head
- pc_out  out  XLEN  PC of head
- op  out  6  ir[31:26]
- funct  out  6  ir[5:0]
- ar  out  5  ir[25:21]
- br  out  5  ir[20:16]
- rdr  out  5  destination register
- imm_ext  out  XLEN  extended immediate
- ind  out  26  ir[25:0]
- reg_we  out  1  entry writes register file
- is_load, is_store, is_branch, is_jump  out  1 each  class flags
- illegal  out  1  unknown opcode (see Optional Feature)

Behaviour:
- Interface: single clock clk; reset rst is synchronous, active-high.
- Reset: FIFO count=0; rd/wr pointers=0; out_valid=0; in_ready=0 while rst high, 1 the cycle after.
- Head field outputs: all 0 when empty.
- Handshake:
  - push when in_valid&&in_ready; in_ready = !full && !rst.
  - pop when out_valid&&out_ready; out_valid = count!=0.
  - Push and pop in the same cycle: count unchanged; legal at any non-full count. No bypass when full.
- Latency: accepted word appears at head one cycle later (FIFO was empty and not flushed). Outputs are registered and stable while out_valid && !out_ready.
- Decode (computed on ir at push, stored in entry):
  - rdr: rt (ir[20:16]) for lw 100011, sw 101011, addi 001000, addiu 001001, slti 001010, andi 001100, ori 001101, xori 001110, lui 001111.
  - rdr: LINK_REG for jal 000011; rd (ir[15:11]) otherwise.
  - imm_ext: zero-extended for andi/ori/xori; {imm,16'b0} for lui; sign-extended otherwise.
  - reg_we: 1 for R-type (op 000000) except funct jr 001000; 1 for lw, ALU-immediates, jal; 0 otherwise; forced 0 when rdr==0.
  - is_load=lw; is_store=sw; is_branch=beq 000100 | bne 000101; is_jump=j 000010 | jal | (R-type & funct jr).
- Flush:
  - Next cycle count=0 and pointers reset.
  - A push presented in the flush cycle is dropped, and in_ready is 0 that cycle.
  - A pop in the flush cycle completes normally.
- Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
- Reset asserted mid-stream: all entries discarded, identical to flush.

Optional Feature:
- Macro: IRE_ILLEGAL_EN.
- Defined:
  - Opcodes outside the set above set illegal=1 in the entry.
  - Forces reg_we=0 and all class flags 0 for that entry.
  - Adds an internal saturating 16-bit illegal_cnt, incremented on pop of an illegal entry and cleared by rst.
- Undefined: illegal tied 0; unknown opcodes decode with rdr=rd and reg_we=0; no counter.

Decomposition:
- Package ire_pkg:
  - Opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, ... OP_JAL) and FUNCT_JR.
  - Packed struct typedef ire_entry_t holding all decoded fields plus pc.
- Sub-module ire_decode: pure combinational ir -> ire_entry_t.
- ire_stage instantiates ire_decode and owns the FIFO and handshake.

Test Plan:
- Reset, push lw 0x8C410004 at pc 0x100, out_ready=1 -> next cycle out_valid=1, ar=2, br=1, rdr=1, imm_ext=0x00000004, is_load=1, reg_we=1, pc_out=0x100.
- Decode checks:
  - ori 0x3421FFFF -> imm_ext=0x0000FFFF.
  - addi 0x2021FFFF -> imm_ext=0xFFFFFFFF.
  - lui 0x3C011234 -> imm_ext=0x12340000.
  - jal 0x0C000010 -> rdr=31, is_jump=1, reg_we=1.
- Backpressure: out_ready=0, push 3 words with DEPTH=2 -> in_ready=0 after 2nd accept; 3rd held; release -> order preserved, no loss or duplicate.
- Flush with 2 entries buffered and in_valid=1 -> next cycle out_valid=0; the word presented in the flush cycle is not accepted.
- R-type add with rd=0 (0x00000020) -> reg_we=0. jr 0x03E00008 -> is_jump=1, reg_we=0.
- With IRE_ILLEGAL_EN, push op 111111 -> illegal=1, reg_we=0, illegal_cnt=1 after pop. Without the macro -> illegal=0.

Source files
------------

// File: rtl/ire_pkg.sv
// Shared opcode constants and the decoded-entry layout for the instruction
// register/extract stage.
package ire_pkg;

    // Widest supported XLEN; narrower builds leave the upper bits at zero.
    localparam int IRE_XLEN_MAX = 64;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FUNCT_JR = 6'b001000;

    typedef struct packed {
        logic [IRE_XLEN_MAX-1:0] pc;
        logic [5:0]              op;
        logic [5:0]              funct;
        logic [4:0]              ar;
        logic [4:0]              br;
        logic [4:0]              rdr;
        logic [IRE_XLEN_MAX-1:0] imm_ext;
        logic [25:0]             ind;
        logic                    reg_we;
        logic                    is_load;
        logic                    is_store;
        logic                    is_branch;
        logic                    is_jump;
        logic                    illegal;
    } ire_entry_t;

endpackage

// File: rtl/ire_stage_decode.sv
// Combinational decode of one MIPS32 instruction word into an ire_entry_t.
// IRE_ILLEGAL_EN: flag opcodes outside the supported set as illegal.
module ire_decode
    import ire_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int LINK_REG = 31
) (
    input  logic [31:0]     ir,
    input  logic [XLEN-1:0] pc,
    output ire_entry_t      entry
);

    logic [5:0]      op;
    logic [5:0]      funct;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            dst_rt;
    logic            we;

    assign op    = ir[31:26];
    assign funct = ir[5:0];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];

    always_comb begin
        imm    = {{(XLEN-16){ir[15]}}, ir[15:0]};
        dst_rt = 1'b0;
        we     = 1'b0;
        case (op)
            OP_RTYPE: we = (funct != FUNCT_JR);
            OP_LW: begin
                dst_rt = 1'b1;
                we     = 1'b1;
            end
            OP_SW: dst_rt = 1'b1;
            OP_ADDI, OP_ADDIU, OP_SLTI: begin
                dst_rt = 1'b1;
                we     = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                dst_rt = 1'b1;
                we     = 1'b1;
                imm    = {{(XLEN-16){1'b0}}, ir[15:0]};
            end
            OP_LUI: begin
                dst_rt     = 1'b1;
                we         = 1'b1;
                imm        = '0;
                imm[31:16] = ir[15:0];
            end
            OP_JAL: we = 1'b1;
            default: we = 1'b0;
        endcase
    end

    always_comb begin
        entry                 = '0;
        entry.pc[XLEN-1:0]      = pc;
        entry.op              = op;
        entry.funct           = funct;
        entry.ar              = ir[25:21];
        entry.br              = rt;
        entry.rdr             = (op == OP_JAL) ? 5'(LINK_REG) : (dst_rt ? rt : rd);
        entry.imm_ext[XLEN-1:0] = imm;
        entry.ind             = ir[25:0];
        entry.is_load         = (op == OP_LW);
        entry.is_store        = (op == OP_SW);
        entry.is_branch       = (op == OP_BEQ) || (op == OP_BNE);
        entry.is_jump         = (op == OP_J) || (op == OP_JAL) ||
                                ((op == OP_RTYPE) && (funct == FUNCT_JR));
        // Writes to r0 are architecturally discarded, so never request them.
        entry.reg_we          = we && (entry.rdr != 5'd0);
`ifdef IRE_ILLEGAL_EN
        entry.illegal = !(op inside {OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
                                     OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI,
                                     OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW});
        if (entry.illegal) begin
            entry.reg_we    = 1'b0;
            entry.is_load   = 1'b0;
            entry.is_store  = 1'b0;
            entry.is_branch = 1'b0;
            entry.is_jump   = 1'b0;
        end
`else
        entry.illegal = 1'b0;
`endif
    end

endmodule

// File: rtl/ire_stage.sv
// Registered instruction-extract stage: decodes at accept time and buffers
// decoded entries in a DEPTH-deep FIFO. IRE_ILLEGAL_EN adds illegal tracking.
module ire_stage
    import ire_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 2,
    parameter int LINK_REG = 31
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     ir,
    input  logic [XLEN-1:0] pc_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] pc_out,
    output logic [5:0]      op,
    output logic [5:0]      funct,
    output logic [4:0]      ar,
    output logic [4:0]      br,
    output logic [4:0]      rdr,
    output logic [XLEN-1:0] imm_ext,
    output logic [25:0]     ind,
    output logic            reg_we,
    output logic            is_load,
    output logic            is_store,
    output logic            is_branch,
    output logic            is_jump,
    output logic            illegal
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ire_entry_t      mem [DEPTH];
    ire_entry_t      dec_entry;
    ire_entry_t      head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_n;
    logic            full;
    logic            push;
    logic            pop;
    logic            unused_hi;

    ire_decode #(
        .XLEN     (XLEN),
        .LINK_REG (LINK_REG)
    ) u_decode (
        .ir    (ir),
        .pc    (pc_in),
        .entry (dec_entry)
    );

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; valid never depends on ready. No push is taken while full,
    // in reset, or flushing; a pop during flush still completes.
    assign full      = (count == CW'(DEPTH));
    assign in_ready  = !full && !rst && !flush;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        case ({push, pop})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            count <= count_n;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dec_entry;
    end

    assign head = out_valid ? mem[rd_ptr] : '0;

    assign pc_out    = head.pc[XLEN-1:0];
    assign op        = head.op;
    assign funct     = head.funct;
    assign ar        = head.ar;
    assign br        = head.br;
    assign rdr       = head.rdr;
    assign imm_ext   = head.imm_ext[XLEN-1:0];
    assign ind       = head.ind;
    assign reg_we    = head.reg_we;
    assign is_load   = head.is_load;
    assign is_store  = head.is_store;
    assign is_branch = head.is_branch;
    assign is_jump   = head.is_jump;
    assign illegal   = head.illegal;

    // Upper bits beyond XLEN are always zero in stored entries.
    assign unused_hi = ^{head.pc, head.imm_ext};

`ifdef IRE_ILLEGAL_EN
    logic [15:0] illegal_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (pop && head.illegal && (illegal_cnt != 16'hFFFF)) begin
            illegal_cnt <= illegal_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ire_stage.sv
// Self-checking bench for ire_stage: directed decode cases, backpressure,
// flush, and a randomized back-to-back run against a reference decoder.
module tb_ire_stage;

    localparam int XLEN = 32;
    localparam int W    = 2 * XLEN + 6 + 6 + 5 + 5 + 5 + 26 + 6;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     ir;
    logic [XLEN-1:0] pc_in;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] pc_out;
    logic [5:0]      op;
    logic [5:0]      funct;
    logic [4:0]      ar;
    logic [4:0]      br;
    logic [4:0]      rdr;
    logic [XLEN-1:0] imm_ext;
    logic [25:0]     ind;
    logic            reg_we;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic            is_jump;
    logic            illegal;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs;
    logic [W-1:0] e;

    ire_stage #(.XLEN(XLEN), .DEPTH(2), .LINK_REG(31)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .ir(ir), .pc_in(pc_in),
        .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out),
        .op(op), .funct(funct), .ar(ar), .br(br), .rdr(rdr),
        .imm_ext(imm_ext), .ind(ind), .reg_we(reg_we),
        .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
        .is_jump(is_jump), .illegal(illegal)
    );

    assign obs = {pc_out, op, funct, ar, br, rdr, imm_ext, ind,
                  reg_we, is_load, is_store, is_branch, is_jump, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

    // Reference decoder written from the instruction-set tables.
    function automatic logic [W-1:0] model(input logic [31:0] w, input logic [XLEN-1:0] p);
        logic [5:0] o, f;
        logic [4:0] rt, rd, dst;
        logic [XLEN-1:0] imm;
        logic wr, we, ld, st, bra, jmp, ill;
        o   = w[31:26];
        f   = w[5:0];
        rt  = w[20:16];
        rd  = w[15:11];
        ld  = (o == 6'h23);
        st  = (o == 6'h2B);
        bra = (o == 6'h04) || (o == 6'h05);
        jmp = (o == 6'h02) || (o == 6'h03) || (o == 6'h00 && f == 6'h08);
        if (o == 6'h03)
            dst = 5'd31;
        else if (o inside {6'h23, 6'h2B, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F})
            dst = rt;
        else
            dst = rd;
        if (o inside {6'h0C, 6'h0D, 6'h0E})
            imm = {16'h0000, w[15:0]};
        else if (o == 6'h0F)
            imm = {w[15:0], 16'h0000};
        else
            imm = {{16{w[15]}}, w[15:0]};
        wr  = (o == 6'h00 && f != 6'h08) || ld || (o == 6'h03) ||
              (o inside {6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F});
        we  = wr && (dst != 5'd0);
        ill = 1'b0;
`ifdef IRE_ILLEGAL_EN
        ill = !(o inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                          6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B});
        if (ill) begin
            we = 1'b0; ld = 1'b0; st = 1'b0; bra = 1'b0; jmp = 1'b0;
        end
`endif
        return {p, o, f, w[25:21], rt, dst, imm, w[25:0], we, ld, st, bra, jmp, ill};
    endfunction

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; ir = 32'h8C410004;
        pc_in = '0; out_ready = 1'b0;
        repeat (2) cyc();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %0b expected 0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        cyc();
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_high: got %0b expected 1", in_ready); end
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_head_zero: got %h expected 0", obs); end
        cyc();
    endtask

    task automatic test_lw;
        in_valid = 1'b1; ir = 32'h8C410004; pc_in = 32'h100; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_valid && in_ready) exp_q.push_back(model(ir, pc_in));
        else begin errors++; $display("FAIL lw_accept: got in_ready=%0b expected 1", in_ready); end
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL lw_latency: got out_valid=%0b expected 1", out_valid); end
        checks++;
        if (pc_out !== 32'h100 || ar !== 5'd2 || br !== 5'd1 || rdr !== 5'd1 ||
            imm_ext !== 32'h4 || is_load !== 1'b1 || reg_we !== 1'b1) begin
            errors++;
            $display("FAIL lw_fields: got pc=%h ar=%0d br=%0d rdr=%0d imm=%h ld=%0b we=%0b expected pc=100 ar=2 br=1 rdr=1 imm=4 ld=1 we=1",
                     pc_out, ar, br, rdr, imm_ext, is_load, reg_we);
        end
        if (out_valid && out_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL lw_scoreboard: got %h expected %h", obs, e); end
        end
        cyc();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL lw_drained: got out_valid=%0b expected 0", out_valid); end
        cyc();
    endtask

    localparam logic [31:0] DEC_W    [6] = '{32'h3421FFFF, 32'h2021FFFF, 32'h3C011234,
                                             32'h0C000010, 32'h00000020, 32'h03E00008};
    localparam logic [31:0] DEC_IMM  [6] = '{32'h0000FFFF, 32'hFFFFFFFF, 32'h12340000,
                                             32'h00000010, 32'h00000020, 32'h00000008};
    localparam logic [4:0]  DEC_RDR  [6] = '{5'd1, 5'd1, 5'd1, 5'd31, 5'd0, 5'd0};
    localparam logic        DEC_WE   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam logic        DEC_JUMP [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic test_decode;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; ir = DEC_W[i]; pc_in = 32'h200 + 32'(4 * i); out_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (in_valid && in_ready) exp_q.push_back(model(ir, pc_in));
            else begin errors++; $display("FAIL decode_accept_%0d: got in_ready=%0b expected 1", i, in_ready); end
            cyc();
            in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (imm_ext !== DEC_IMM[i] || rdr !== DEC_RDR[i] || reg_we !== DEC_WE[i] || is_jump !== DEC_JUMP[i]) begin
                errors++;
                $display("FAIL decode_fields_%0d: got imm=%h rdr=%0d we=%0b jump=%0b expected imm=%h rdr=%0d we=%0b jump=%0b",
                         i, imm_ext, rdr, reg_we, is_jump, DEC_IMM[i], DEC_RDR[i], DEC_WE[i], DEC_JUMP[i]);
            end
            checks++;
            if (!(out_valid && out_ready) || exp_q.size() == 0) begin
                errors++; $display("FAIL decode_pop_%0d: got out_valid=%0b expected 1", i, out_valid);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e) begin errors++; $display("FAIL decode_scoreboard_%0d: got %h expected %h", i, obs, e); end
            end
            cyc();
        end
    endtask

    task automatic test_illegal;
        in_valid = 1'b1; ir = 32'hFC00ABCD; pc_in = 32'h280; out_ready = 1'b1;
        @(negedge clk);
        if (in_valid && in_ready) exp_q.push_back(model(ir, pc_in));
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
`ifdef IRE_ILLEGAL_EN
        if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag: got %0b expected 1", illegal); end
`else
        if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_flag: got %0b expected 0", illegal); end
`endif
        checks++;
        if (reg_we !== 1'b0) begin errors++; $display("FAIL illegal_reg_we: got %0b expected 0", reg_we); end
        checks++;
        if (!(out_valid && out_ready) || exp_q.size() == 0) begin
            errors++; $display("FAIL illegal_pop: got out_valid=%0b expected 1", out_valid);
        end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin errors++; $display("FAIL illegal_scoreboard: got %h expected %h", obs, e); end
        end
        cyc();
`ifdef IRE_ILLEGAL_EN
        @(negedge clk);
        checks++;
        if (dut.illegal_cnt !== 16'd1) begin errors++; $display("FAIL illegal_cnt: got %0d expected 1", dut.illegal_cnt); end
        cyc();
`endif
    endtask

    task automatic test_backpressure;
        logic [31:0] bp_w [3];
        int k, pops;
        bp_w[0] = 32'h8C220008; bp_w[1] = 32'hAC430010; bp_w[2] = 32'h10220003;
        k = 0; pops = 0;
        for (int c = 0; c < 30; c++) begin
            out_ready = (c >= 5);
            in_valid  = (k < 3);
            if (k < 3) begin ir = bp_w[k]; pc_in = 32'h300 + 32'(4 * k); end
            @(negedge clk);
            if (c == 3) begin
                checks++;
                if (in_ready !== 1'b0 || k != 2) begin
                    errors++; $display("FAIL bp_full: got in_ready=%0b accepted=%0d expected in_ready=0 accepted=2", in_ready, k);
                end
            end
            if (out_valid && !out_ready && exp_q.size() != 0) begin
                checks++;
                if (obs !== exp_q[0]) begin errors++; $display("FAIL bp_stable: got %h expected %h", obs, exp_q[0]); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL bp_extra_pop: got pop expected none"); end
                else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin errors++; $display("FAIL bp_order: got %h expected %h", obs, e); end
                end
                pops++;
            end
            if (in_valid && in_ready) begin exp_q.push_back(model(ir, pc_in)); k++; end
            cyc();
            if (k == 3 && pops == 3) break;
        end
        in_valid = 1'b0;
        checks++;
        if (pops != 3 || k != 3 || exp_q.size() != 0) begin
            errors++; $display("FAIL bp_count: got pops=%0d accepted=%0d expected 3 and 3", pops, k);
        end
    endtask

    task automatic test_flush;
        int k;
        k = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 10 && k < 2; c++) begin
            in_valid = 1'b1; ir = 32'h20630001 + 32'(k); pc_in = 32'h400 + 32'(4 * k);
            @(negedge clk);
            if (in_valid && in_ready) begin exp_q.push_back(model(ir, pc_in)); k++; end
            cyc();
        end
        flush = 1'b1; in_valid = 1'b1; ir = 32'h8C410004; pc_in = 32'h500; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %0b expected 0", in_ready); end
        checks++;
        if (!(out_valid && out_ready) || exp_q.size() == 0) begin
            errors++; $display("FAIL flush_pop: got out_valid=%0b expected 1", out_valid);
        end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin errors++; $display("FAIL flush_pop_data: got %h expected %h", obs, e); end
        end
        exp_q.delete();
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || obs !== '0) begin
            errors++; $display("FAIL flush_empty: got out_valid=%0b head=%h expected 0", out_valid, obs);
        end
        cyc();
    endtask

    localparam logic [5:0] RND_OP [16] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                                           6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};

    task automatic test_back_to_back;
        logic [31:0] w;
        for (int c = 0; c < 300; c++) begin
            w = {RND_OP[$urandom_range(0, 15)], 26'($urandom)};
            if (w[31:26] == 6'h00 && $urandom_range(0, 3) == 0) w[5:0] = 6'h08;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            ir        = w;
            pc_in     = 32'($urandom) & 32'hFFFF_FFFC;
            @(negedge clk);
            checks++;
            if (out_valid !== (exp_q.size() != 0)) begin
                errors++; $display("FAIL b2b_valid_%0d: got %0b expected %0b", c, out_valid, exp_q.size() != 0);
            end
            if (out_valid && out_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (obs !== e) begin errors++; $display("FAIL b2b_data_%0d: got %h expected %h", c, obs, e); end
            end
            if (in_valid && in_ready) exp_q.push_back(model(ir, pc_in));
            if (flush) exp_q.delete();
            cyc();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            if (out_valid && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (obs !== e) begin errors++; $display("FAIL b2b_drain: got %h expected %h", obs, e); end
            end
            cyc();
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_final: got pending=%0d out_valid=%0b expected 0 and 0", exp_q.size(), out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_decode();
        test_illegal();
        test_backpressure();
        test_flush();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
